wb_stage: RTL

- Final (writeback) stage of the 16-bit pipeline; consumes the execute-2 result, the instruction word and the PC of each retiring instruction.
- Owns the 16x16 architectural register file, with two combinational read ports for the fetch/register-read stage.
- Resolves jumps by redirecting fetch and squashing younger in-flight instructions; also handles halt and counts retired instructions.

---
 rtl/wb_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage: owns the architectural register file, commits results,
// resolves jumps (redirect + squash of younger instructions), halts and counts retirements.
module wb_stage #(
  parameter int unsigned FLUSH_DEPTH = 3,
  parameter int unsigned NREGS       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     x2_valid,
  input  logic [15:0]              x2_ins,
  input  logic [15:0]              x2_pc,
  input  logic [15:0]              x2_result,
  input  logic [$clog2(NREGS)-1:0] fr_ra_addr,
  input  logic [$clog2(NREGS)-1:0] fr_rb_addr,
  output logic [15:0]              fr_ra_data,
  output logic [15:0]              fr_rb_data,
  output logic                     redirect_valid,
  output logic [15:0]              redirect_pc,
  output logic                     wb_valid,
  output logic [$clog2(NREGS)-1:0] wb_addr,
  output logic [15:0]              wb_data,
  output logic                     halted,
  output logic [15:0]              retired_count
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned FW = $clog2(FLUSH_DEPTH + 1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_ST   = 4'h4,
    OP_JMP  = 4'h6,
    OP_LD   = 4'h7,
    OP_VLD  = 4'hC,
    OP_VST  = 4'hD,
    OP_DOT  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  logic [15:0]   regs [NREGS];
  logic [FW-1:0] flush_cnt;
  opcode_e       op;
  logic [AW-1:0] rt;
  logic          is_writer, is_jump, is_halt;
  logic          commit, squash, taken, wr_en;
  logic          unused_ins;

  assign op         = opcode_e'(x2_ins[15:12]);
  assign rt         = x2_ins[AW-1:0];
  assign unused_ins = ^x2_ins[11:AW];

  always_comb begin
    is_writer = 1'b0;
    is_jump   = 1'b0;
    is_halt   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_DOT, OP_LD: is_writer = 1'b1;
      OP_JMP:                                        is_jump   = 1'b1;
      OP_HALT:                                       is_halt   = 1'b1;
      default: ;
    endcase
  end

  // Squash takes priority over halted so a pending flush still drains.
  assign commit = x2_valid && (flush_cnt == '0) && !halted;
  assign squash = x2_valid && (flush_cnt != '0);
  assign taken  = x2_result != (x2_pc + 16'd2);
  assign wr_en  = commit && is_writer && (rt != '0);

  // Register 0 is never written, but the explicit zero keeps reads independent of reset.
  assign fr_ra_data = (fr_ra_addr == '0) ? '0 :
                      (wr_en && fr_ra_addr == rt) ? x2_result : regs[fr_ra_addr];
  assign fr_rb_data = (fr_rb_addr == '0) ? '0 :
                      (wr_en && fr_rb_addr == rt) ? x2_result : regs[fr_rb_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rt] <= x2_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      wb_valid       <= 1'b0;
      wb_addr        <= '0;
      wb_data        <= '0;
      halted         <= 1'b0;
      retired_count  <= '0;
    end else begin
      redirect_valid <= commit && is_jump && taken;
      wb_valid       <= commit && is_writer;
      if (commit) retired_count <= retired_count + 16'd1;
      if (commit && is_writer) begin
        wb_addr <= rt;
        wb_data <= x2_result;
      end
      if (commit && is_jump && taken) begin
        redirect_pc <= x2_result;
        flush_cnt   <= FW'(FLUSH_DEPTH);
      end else if (squash) begin
        flush_cnt <= flush_cnt - FW'(1);
      end
      if (commit && is_halt) halted <= 1'b1;
    end
  end

endmodule
